// File: rtl/whack_pkg.sv
// whack_pkg: shared types and constants for the whack-a-mole game blocks.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: state_t enum, LFSR width/taps/seed, default timing constants, lfsr_next().
package whack_pkg;

  // Game FSM states shared by the mole detector and the control FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_t;

  // 8-bit Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  // Bit positions 8,6,5,4 of the polynomial map to register bits 7,5,4,3.
  localparam int             LFSR_W        = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;

  // Default game timing at a 50 MHz core clock.
  localparam int NUM_HOLES_DEF      = 4;
  localparam int MOLE_UP_CYCLES_DEF = 50_000_000;  // 1 s
  localparam int GAP_CYCLES_DEF     = 12_500_000;  // 250 ms

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  // A nonzero state never maps to zero with a maximal-length polynomial.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: brings raw asynchronous keys into clk and flags their rising edges.
// Latency: a key sampled high at edge 0 shows on rise after edge 1 (comb from sync2/prev).
// Backpressure: none; each rising edge is reported for exactly one cycle.
// Ports: clk, Resetn (async active-low), keys[WIDTH] raw in, rise[WIDTH] one-cycle out.
module key_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  // sync1/sync2 form the metastability synchronizer; prev holds the last
  // synchronized value so a held key produces only one rise.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/mole_hit_detector.sv
// mole_hit_detector: picks a pseudo-random hole, shows one mole per window, scores key hits.
// Latency: key high before edge 0 -> player_signal/miss_pulse high after edge 2 for one cycle.
// Backpressure: none; pulses are fire-and-forget, the score datapath must take every one.
// Ports: clk, Resetn (async active-low), enable (round active), keys[NUM_HOLES] raw buttons;
//        mole_onehot/mole_valid (display), player_signal (hit), miss_pulse (wrong/timeout),
//        mole_count (moles shown this round, saturating at 255).
module mole_hit_detector
  import whack_pkg::*;
#(
  parameter int              NUM_HOLES      = NUM_HOLES_DEF,
  parameter int              MOLE_UP_CYCLES = MOLE_UP_CYCLES_DEF,
  parameter int              GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic                 clk,
  input  logic                 Resetn,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] keys,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic                 mole_valid,
  output logic                 player_signal,
  output logic                 miss_pulse,
  output logic [7:0]           mole_count
);

  // One counter serves both GAP and UP; it is cleared on every state entry,
  // so it only has to cover the longer of the two windows.
  localparam int CNT_SPAN = (MOLE_UP_CYCLES > GAP_CYCLES) ? MOLE_UP_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;
  localparam int HOLE_W   = (NUM_HOLES > 2) ? $clog2(NUM_HOLES) : 1;

  localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     UP_LAST   = CNT_W'(MOLE_UP_CYCLES - 1);
  localparam logic [HOLE_W-1:0]    HOLE_LAST = HOLE_W'(NUM_HOLES - 1);
  localparam logic [LFSR_W-1:0]    HOLES_L   = LFSR_W'(NUM_HOLES);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0  = NUM_HOLES'(1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LFSR_W-1:0]    lfsr;
  logic [HOLE_W-1:0]    prev_hole;
  logic                 prev_valid;
  logic [NUM_HOLES-1:0] rise;

  logic [HOLE_W-1:0]    raw_idx;
  logic [HOLE_W-1:0]    pick_idx;
  logic [NUM_HOLES-1:0] pick_onehot;
  logic                 hit_rise;
  logic                 wrong_rise;
  logic                 gap_done;
  logic                 up_done;

  key_edge_sync #(
    .WIDTH (NUM_HOLES)
  ) u_keys (
    .clk    (clk),
    .Resetn (Resetn),
    .keys   (keys),
    .rise   (rise)
  );

  // Hole selection. The modulo divisor is a constant, so this is plain logic.
  // Until the first mole after reset there is no previous hole to avoid.
  assign raw_idx = HOLE_W'(lfsr % HOLES_L);

  always_comb begin
    pick_idx = raw_idx;
    if (prev_valid && (raw_idx == prev_hole)) begin
      pick_idx = (raw_idx == HOLE_LAST) ? '0 : raw_idx + HOLE_W'(1);
    end
  end

  assign pick_onehot = ONE_HOT0 << pick_idx;

  // Any rise outside the current hole is a wrong key, and it vetoes a
  // simultaneous correct-key rise.
  assign hit_rise   = |(rise & mole_onehot);
  assign wrong_rise = |(rise & ~mole_onehot);
  assign gap_done   = (cnt == GAP_LAST);
  assign up_done    = (cnt == UP_LAST);

  // The LFSR free-runs in every state so the hole sequence depends on how
  // long the player takes, not only on the mole index.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      prev_hole     <= '0;
      prev_valid    <= 1'b0;
      mole_onehot   <= '0;
      mole_valid    <= 1'b0;
      player_signal <= 1'b0;
      miss_pulse    <= 1'b0;
      mole_count    <= '0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      player_signal <= 1'b0;
      miss_pulse    <= 1'b0;

      if (!enable) begin
        // Abort: drop the mole silently; mole_count is kept for the
        // display until the next round starts.
        state       <= IDLE;
        cnt         <= '0;
        mole_onehot <= '0;
        mole_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= GAP;
            cnt        <= '0;
            mole_count <= '0;
          end

          GAP: begin
            if (gap_done) begin
              state       <= UP;
              cnt         <= '0;
              mole_onehot <= pick_onehot;
              mole_valid  <= 1'b1;
              prev_hole   <= pick_idx;
              prev_valid  <= 1'b1;
              if (mole_count != 8'hFF) begin
                mole_count <= mole_count + 8'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          UP: begin
            if (wrong_rise) begin
              // The mole normally stays up after a wrong key, but the window
              // still ends on its last cycle; one miss covers both causes.
              miss_pulse <= 1'b1;
              if (up_done) begin
                state       <= GAP;
                cnt         <= '0;
                mole_onehot <= '0;
                mole_valid  <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (hit_rise) begin
              // A hit on the final cycle beats the timeout.
              player_signal <= 1'b1;
              state         <= GAP;
              cnt           <= '0;
              mole_onehot   <= '0;
              mole_valid    <= 1'b0;
            end else if (up_done) begin
              miss_pulse  <= 1'b1;
              state       <= GAP;
              cnt         <= '0;
              mole_onehot <= '0;
              mole_valid  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: begin
            state       <= IDLE;
            cnt         <= '0;
            mole_onehot <= '0;
            mole_valid  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_hit_detector.sv
module tb_mole_hit_detector;

  localparam int NH   = 4;
  localparam int UPC  = 8;
  localparam int GAPC = 4;

  logic          clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          enable = 1'b0;
  logic [NH-1:0] keys = '0;
  logic [NH-1:0] mole_onehot;
  logic          mole_valid;
  logic          player_signal;
  logic          miss_pulse;
  logic [7:0]    mole_count;

  mole_hit_detector #(
    .NUM_HOLES      (NH),
    .MOLE_UP_CYCLES (UPC),
    .GAP_CYCLES     (GAPC),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk           (clk),
    .Resetn        (Resetn),
    .enable        (enable),
    .keys          (keys),
    .mole_onehot   (mole_onehot),
    .mole_valid    (mole_valid),
    .player_signal (player_signal),
    .miss_pulse    (miss_pulse),
    .mole_count    (mole_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Scoreboard entries: kind 1 = player_signal, 2 = miss_pulse; at = cycle index.
  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  function automatic ev_t mk_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    return e;
  endfunction

  function automatic logic [NH-1:0] oh(input int idx);
    logic [NH-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (player_signal === 1'b1) obs_q.push_back(mk_ev(1, cyc));
    if (miss_pulse === 1'b1) obs_q.push_back(mk_ev(2, cyc));
  end

  // Reference LFSR from the polynomial x^8+x^6+x^5+x^4+1; m_lfsr_q is the
  // value that was in effect at the most recent edge.
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_q;
  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      m_lfsr   <= 8'hA5;
      m_lfsr_q <= 8'hA5;
    end else begin
      m_lfsr_q <= m_lfsr;
      m_lfsr   <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  int m_prev = 0;
  bit m_prev_valid = 1'b0;
  int exp_count = 0;
  int cur_at = 0;
  int cur_hole = 0;

  task automatic step_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Waits for mole_valid and returns the hole the reference model predicts.
  task automatic await_mole(input int budget, output int at, output int hole, output bit ok);
    int idx;
    ok = 1'b0;
    at = -1;
    hole = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mole_valid === 1'b1) begin
        idx = m_lfsr_q % NH;
        if (m_prev_valid && idx == m_prev) idx = (idx + 1) % NH;
        m_prev = idx;
        m_prev_valid = 1'b1;
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        hole = idx;
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    enable = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    checks++; if (mole_onehot !== '0) begin failures++; $display("FAIL reset_onehot: got %b want 0000", mole_onehot); end
    checks++; if (mole_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", mole_valid); end
    checks++; if (player_signal !== 1'b0) begin failures++; $display("FAIL reset_player: got %b want 0", player_signal); end
    checks++; if (miss_pulse !== 1'b0) begin failures++; $display("FAIL reset_miss: got %b want 0", miss_pulse); end
    checks++; if (mole_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", mole_count); end
    obs_q.delete();
    exp_q.delete();
    m_prev_valid = 1'b0;
    exp_count = 0;
    Resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mole_valid !== 1'b0) begin failures++; $display("FAIL idle_no_enable: valid got %b want 0", mole_valid); end
  endtask

  task automatic test_first_mole;
    int c, at, hole;
    bit ok;
    c = cyc;
    enable = 1'b1;
    await_mole(20, at, hole, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL first_mole_wait: no mole within 20 cycles, want one at cycle %0d", c + 1 + GAPC);
    end else begin
      if (at != c + 1 + GAPC) begin failures++; $display("FAIL first_mole_cycle: got %0d want %0d", at, c + 1 + GAPC); end
      checks++; if (mole_onehot !== oh(hole)) begin failures++; $display("FAIL first_mole_hole: got %b want %b", mole_onehot, oh(hole)); end
      checks++; if (mole_count !== 8'd1) begin failures++; $display("FAIL first_mole_count: got %0d want 1", mole_count); end
    end
    cur_at = at;
    cur_hole = hole;
  endtask

  task automatic test_hit;
    ev_t e, o;
    keys = oh(cur_hole);
    exp_q.push_back(mk_ev(1, cur_at + 3));
    step_to(cur_at + 3);
    checks++; if (player_signal !== 1'b1) begin failures++; $display("FAIL hit_pulse: got %b want 1", player_signal); end
    checks++; if (mole_valid !== 1'b0) begin failures++; $display("FAIL hit_valid_fall: got %b want 0", mole_valid); end
    checks++; if (miss_pulse !== 1'b0) begin failures++; $display("FAIL hit_no_miss: got %b want 0", miss_pulse); end
    keys = '0;
    @(negedge clk);
    checks++; if (player_signal !== 1'b0) begin failures++; $display("FAIL hit_width: got %b want 0 one cycle later", player_signal); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL hit_sb: missing kind %0d at %0d", e.kind, e.at); end
      else begin o = obs_q.pop_front(); if (o.kind != e.kind || o.at != e.at) begin failures++; $display("FAIL hit_sb: got kind %0d at %0d want kind %0d at %0d", o.kind, o.at, e.kind, e.at); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL hit_sb_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    cur_at = cur_at + 3;
  endtask

  task automatic test_timeout;
    int at, hole, at2, hole2;
    bit ok;
    ev_t e, o;
    await_mole(20, at, hole, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_mole_wait: no mole, want one at %0d", cur_at + GAPC); end
    else if (at != cur_at + GAPC) begin failures++; $display("FAIL gap_after_hit: got %0d want %0d", at, cur_at + GAPC); end
    checks++; if (mole_onehot !== oh(hole)) begin failures++; $display("FAIL timeout_hole: got %b want %b", mole_onehot, oh(hole)); end
    exp_q.push_back(mk_ev(2, at + UPC));
    step_to(at + UPC - 1);
    checks++; if (mole_valid !== 1'b1) begin failures++; $display("FAIL window_last_cycle: valid got %b want 1", mole_valid); end
    step_to(at + UPC);
    checks++; if (miss_pulse !== 1'b1) begin failures++; $display("FAIL timeout_miss: got %b want 1", miss_pulse); end
    checks++; if (mole_valid !== 1'b0) begin failures++; $display("FAIL timeout_valid: got %b want 0", mole_valid); end
    await_mole(20, at2, hole2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL next_mole_wait: no mole, want one at %0d", at + UPC + GAPC); end
    else if (at2 != at + UPC + GAPC) begin failures++; $display("FAIL next_mole_cycle: got %0d want %0d", at2, at + UPC + GAPC); end
    checks++; if (mole_onehot !== oh(hole2)) begin failures++; $display("FAIL next_mole_hole: got %b want %b", mole_onehot, oh(hole2)); end
    checks++; if (mole_onehot === oh(hole)) begin failures++; $display("FAIL next_mole_differs: got %b want not %b", mole_onehot, oh(hole)); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL timeout_sb: missing kind %0d at %0d", e.kind, e.at); end
      else begin o = obs_q.pop_front(); if (o.kind != e.kind || o.at != e.at) begin failures++; $display("FAIL timeout_sb: got kind %0d at %0d want kind %0d at %0d", o.kind, o.at, e.kind, e.at); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL timeout_sb_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    cur_at = at2;
    cur_hole = hole2;
  endtask

  task automatic test_wrong_then_right;
    int w, at, hole;
    bit ok;
    ev_t e, o;
    w = cur_at;
    keys = oh((cur_hole + 1) % NH);
    exp_q.push_back(mk_ev(2, w + 3));
    step_to(w + 3);
    checks++; if (miss_pulse !== 1'b1) begin failures++; $display("FAIL wrong_miss: got %b want 1", miss_pulse); end
    checks++; if (mole_valid !== 1'b1 || mole_onehot !== oh(cur_hole)) begin failures++; $display("FAIL wrong_mole_stays: got %b/%b want 1/%b", mole_valid, mole_onehot, oh(cur_hole)); end
    keys = '0;
    step_to(w + 4);
    keys = oh(cur_hole);
    exp_q.push_back(mk_ev(1, w + 7));
    step_to(w + 7);
    checks++; if (player_signal !== 1'b1 || miss_pulse !== 1'b0) begin failures++; $display("FAIL right_after_wrong: player/miss got %b/%b want 1/0", player_signal, miss_pulse); end
    checks++; if (mole_valid !== 1'b0) begin failures++; $display("FAIL right_after_wrong_valid: got %b want 0", mole_valid); end
    keys = '0;
    await_mole(20, at, hole, ok);
    checks++; if (!ok || mole_onehot !== oh(hole)) begin failures++; $display("FAIL combo_mole: got %b want %b", mole_onehot, oh(hole)); end
    keys = oh(hole) | oh((hole + 1) % NH);
    exp_q.push_back(mk_ev(2, at + 3));
    step_to(at + 3);
    checks++; if (miss_pulse !== 1'b1 || player_signal !== 1'b0) begin failures++; $display("FAIL combo_miss_only: miss/player got %b/%b want 1/0", miss_pulse, player_signal); end
    checks++; if (mole_valid !== 1'b1) begin failures++; $display("FAIL combo_mole_stays: got %b want 1", mole_valid); end
    keys = '0;
    exp_q.push_back(mk_ev(2, at + UPC));
    step_to(at + UPC);
    checks++; if (miss_pulse !== 1'b1 || mole_valid !== 1'b0) begin failures++; $display("FAIL combo_timeout: miss/valid got %b/%b want 1/0", miss_pulse, mole_valid); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL wrong_sb: missing kind %0d at %0d", e.kind, e.at); end
      else begin o = obs_q.pop_front(); if (o.kind != e.kind || o.at != e.at) begin failures++; $display("FAIL wrong_sb: got kind %0d at %0d want kind %0d at %0d", o.kind, o.at, e.kind, e.at); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL wrong_sb_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    cur_at = at + UPC;
  endtask

  task automatic test_held_key;
    int at, hole;
    bit ok;
    ev_t e, o;
    keys = '1;
    await_mole(20, at, hole, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL held_mole_wait: no mole, want one at %0d", cur_at + GAPC); end
    else if (at != cur_at + GAPC) begin failures++; $display("FAIL held_mole_cycle: got %0d want %0d", at, cur_at + GAPC); end
    step_to(at + 3);
    #1;
    checks++; if (obs_q.size() != 0 || mole_valid !== 1'b1) begin failures++; $display("FAIL held_no_score: got %0d pulses valid %b want 0 pulses valid 1", obs_q.size(), mole_valid); end
    keys = '0;
    step_to(at + 5);
    keys = oh(hole);
    exp_q.push_back(mk_ev(1, at + UPC));
    step_to(at + UPC);
    checks++; if (player_signal !== 1'b1 || miss_pulse !== 1'b0) begin failures++; $display("FAIL hit_on_last_cycle: player/miss got %b/%b want 1/0", player_signal, miss_pulse); end
    keys = '0;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL held_sb: missing kind %0d at %0d", e.kind, e.at); end
      else begin o = obs_q.pop_front(); if (o.kind != e.kind || o.at != e.at) begin failures++; $display("FAIL held_sb: got kind %0d at %0d want kind %0d at %0d", o.kind, o.at, e.kind, e.at); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL held_sb_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_abort;
    int at, hole, c, keep;
    bit ok;
    await_mole(20, at, hole, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_mole_wait: no mole within 20 cycles"); end
    keep = exp_count;
    step_to(at + 2);
    enable = 1'b0;
    step_to(at + 3);
    checks++; if (mole_valid !== 1'b0 || mole_onehot !== '0) begin failures++; $display("FAIL abort_clear: valid/onehot got %b/%b want 0/0000", mole_valid, mole_onehot); end
    checks++; if (mole_count !== 8'(keep)) begin failures++; $display("FAIL abort_count_hold: got %0d want %0d", mole_count, keep); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_no_pulse: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
    checks++; if (mole_count !== 8'(keep)) begin failures++; $display("FAIL idle_count_hold: got %0d want %0d", mole_count, keep); end
    @(negedge clk);
    c = cyc;
    enable = 1'b1;
    step_to(c + 1);
    checks++; if (mole_count !== 8'd0) begin failures++; $display("FAIL restart_count_clear: got %0d want 0", mole_count); end
    exp_count = 0;
    await_mole(20, at, hole, ok);
    checks++; if (!ok || at != c + 1 + GAPC) begin failures++; $display("FAIL restart_mole_cycle: got %0d want %0d", at, c + 1 + GAPC); end
    checks++; if (mole_count !== 8'd1 || mole_onehot !== oh(hole)) begin failures++; $display("FAIL restart_mole: count/onehot got %0d/%b want 1/%b", mole_count, mole_onehot, oh(hole)); end
    step_to(at + 2);
    Resetn = 1'b0;
    #1;
    checks++; if ({mole_valid, player_signal, miss_pulse} !== 3'b000 || mole_onehot !== '0) begin failures++; $display("FAIL async_reset_outputs: valid/player/miss/onehot got %b%b%b/%b want 000/0000", mole_valid, player_signal, miss_pulse, mole_onehot); end
    checks++; if (mole_count !== 8'd0) begin failures++; $display("FAIL async_reset_count: got %0d want 0", mole_count); end
    m_prev_valid = 1'b0;
    exp_count = 0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_no_pulse: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_saturation;
    int at, hole, want_cnt;
    bit ok;
    logic [NH-1:0] prev_oh;
    ev_t e, o;
    prev_oh = '0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      await_mole(20, at, hole, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL sat_mole_wait: mole %0d did not appear", i);
        break;
      end
      if (mole_onehot !== oh(hole)) begin failures++; $display("FAIL sat_hole: mole %0d got %b want %b", i, mole_onehot, oh(hole)); end
      if (i > 0) begin
        checks++; if (mole_onehot === prev_oh) begin failures++; $display("FAIL sat_consecutive: mole %0d repeated hole %b", i, mole_onehot); end
      end
      want_cnt = (i + 1 < 255) ? i + 1 : 255;
      checks++; if (mole_count !== 8'(want_cnt)) begin failures++; $display("FAIL sat_count: mole %0d got %0d want %0d", i, mole_count, want_cnt); end
      prev_oh = mole_onehot;
      exp_q.push_back(mk_ev(2, at + UPC));
      step_to(at + UPC);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL sat_sb: missing kind %0d at %0d", e.kind, e.at); end
      else begin o = obs_q.pop_front(); if (o.kind != e.kind || o.at != e.at) begin failures++; $display("FAIL sat_sb: got kind %0d at %0d want kind %0d at %0d", o.kind, o.at, e.kind, e.at); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sat_sb_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_mole();
    test_hit();
    test_timeout();
    test_wrong_then_right();
    test_held_key();
    test_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
